// File: rtl/skew_pkg.sv
// Shared constants, FSM state type and counter sizing for the skew stream sequencer.
package skew_pkg;

  localparam int SKEW_DIM         = 4;
  localparam int SKEW_NUM_DIAG    = 2 * SKEW_DIM - 1;
  localparam int SKEW_FLUSH_BEATS = SKEW_DIM - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Enough bits to hold every terminal count without wrapping.
  function automatic int beat_cnt_width(input int num_diag, input int flush_beats);
    int m;
    m = (num_diag > flush_beats) ? num_diag : flush_beats;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/skew_capture_bank.sv
// Diagonal word store: parallel load on capture, indexed read by beat counter.
module skew_capture_bank
  import skew_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIAG   = SKEW_NUM_DIAG,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [NUM_DIAG-1:0][DATA_WIDTH-1:0] din,
  input  logic [IDX_WIDTH-1:0]               idx,
  output logic [DATA_WIDTH-1:0]              rdata
);

  logic [NUM_DIAG-1:0][DATA_WIDTH-1:0] bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else if (load) begin
      bank <= din;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(idx) < NUM_DIAG) begin
      rdata = bank[idx];
    end
  end

endmodule

// File: rtl/skew_stream_sequencer.sv
// Captures a tile of skewed diagonals and streams them, plus zero flush beats, to the array.
module skew_stream_sequencer
  import skew_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIM_SIZE    = SKEW_DIM,
  parameter int NUM_DIAG    = 2 * DIM_SIZE - 1,
  parameter int FLUSH_BEATS = DIM_SIZE - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] diag0,
  input  logic [DATA_WIDTH-1:0] diag1,
  input  logic [DATA_WIDTH-1:0] diag2,
  input  logic [DATA_WIDTH-1:0] diag3,
  input  logic [DATA_WIDTH-1:0] diag4,
  input  logic [DATA_WIDTH-1:0] diag5,
  input  logic [DATA_WIDTH-1:0] diag6,
  input  logic                  a_ready,
  output logic                  a_valid,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = beat_cnt_width(NUM_DIAG, FLUSH_BEATS);

  state_t                state, state_n;
  logic [CW-1:0]         beat_cnt, beat_cnt_n;
  logic                  load;
  logic [DATA_WIDTH-1:0] bank_word;

  skew_capture_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_DIAG  (NUM_DIAG),
    .IDX_WIDTH (CW)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  ({diag6, diag5, diag4, diag3, diag2, diag1, diag0}),
    .idx  (beat_cnt),
    .rdata(bank_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    load       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          beat_cnt_n = '0;
          state_n    = ST_STREAM;
        end else begin
          state_n    = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (a_ready) begin
          if (beat_cnt == CW'(NUM_DIAG - 1)) begin
            beat_cnt_n = '0;
            state_n    = (FLUSH_BEATS == 0) ? ST_DONE : ST_FLUSH;
          end else begin
            beat_cnt_n = beat_cnt + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (a_ready) begin
          if (beat_cnt == CW'(FLUSH_BEATS - 1)) begin
            beat_cnt_n = '0;
            state_n    = ST_DONE;
          end else begin
            beat_cnt_n = beat_cnt + CW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    a_valid = (state == ST_STREAM) || (state == ST_FLUSH);
    busy    = a_valid;
    done    = (state == ST_DONE);
    a_data  = (state == ST_STREAM) ? bank_word : '0;
  end

endmodule
